// File: rtl/uart_tx_stream.sv
// UART transmitter with a stream input and a small transmit queue.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH FIFO; otherwise a single holding register is used.
module uart_tx_stream #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          TxD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW      = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  logic                 push;
  logic                 pop;
  logic                 q_empty;
  logic [DATA_BITS-1:0] q_head;
  logic                 rdy_en_q, rdy_en_d;

  assign push = in_valid & in_ready;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;

  // FIFO pointer and occupancy update; pointers wrap naturally
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  assign q_empty    = (count_q == '0);
  assign q_head     = mem_q[rptr_q];
  assign fifo_count = count_q;
  assign in_ready   = rdy_en_q && (count_q != CW'(FIFO_DEPTH));
`else
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;

  // Single holding register; only accepts when empty
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (pop) full_d = 1'b0;
    if (push) begin
      hold_d = in_data;
      full_d = 1'b1;
    end
  end

  // Holding register state
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign q_empty    = !full_q;
  assign q_head     = hold_q;
  assign fifo_count = CW'(full_q);
  assign in_ready   = rdy_en_q && !full_q;
`endif

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 last_baud;

  assign last_baud = (baud_q == BW'(CNT_DIV - 1));

  // Frame sequencer; TxD is computed one cycle ahead so it leaves a flop
  always_comb begin
    state_d  = state_q;
    baud_d   = last_baud ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    rdy_en_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!q_empty) begin
          state_d = START;
          pop     = 1'b1;
          shift_d = q_head;
          par_d   = (^q_head) ^ (PARITY == 1);
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (last_baud) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (last_baud) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (last_baud) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (last_baud) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!q_empty) begin
              state_d = START;
              pop     = 1'b1;
              shift_d = q_head;
              par_d   = (^q_head) ^ (PARITY == 1);
              txd_d   = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign TxD  = txd_q;
  assign busy = (state_q != IDLE) || (fifo_count != '0);

endmodule
